// File: rtl/sm_dispatcher_if.sv
// Record-stream and lane-bus bundle for sm_dispatcher.
// slave = dispatcher view; master = upstream source plus lane feeders.
interface sm_dispatcher_if #(
   parameter int NUM_LANES = 4,
   parameter int REC_WIDTH = 316
);
   logic                 s_valid;
   logic                 s_ready;
   logic [REC_WIDTH-1:0] s_data;
   logic                 s_last;
   logic [NUM_LANES-1:0] lane_full;
   logic [NUM_LANES-1:0] lane_done;
   logic [NUM_LANES-1:0] lane_ld;
   logic [REC_WIDTH-1:0] lane_data;

   modport master (
      output s_valid, s_data, s_last, lane_full, lane_done,
      input  s_ready, lane_ld, lane_data
   );

   modport slave (
      input  s_valid, s_data, s_last, lane_full, lane_done,
      output s_ready, lane_ld, lane_data
   );
endinterface

// File: rtl/sm_dispatcher.sv
// Round-robin dispatcher of database records to scoring lanes, with per-lane credit tracking.
// Define SM_DISPATCH_STATS_EN to build the saturating dispatched-record counter on disp_count.
module sm_dispatcher #(
   parameter int NUM_LANES = 4,
   parameter int REC_WIDTH = 316,
   parameter int MAX_OUT   = 2,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   sm_dispatcher_if.slave       bus,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] disp_count
);

   localparam int         PTR_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, DONE} state_t;

   state_t           state;
   logic [PTR_W-1:0] ptr;
   logic             hold_last;
   logic [1:0]       outstanding [NUM_LANES];

   logic [NUM_LANES-1:0] eligible;
   logic                 grant_found;
   logic [PTR_W-1:0]     grant_idx;
   logic                 all_idle;

   always_comb begin
      eligible = '0;
      all_idle = 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
         eligible[i] = !bus.lane_full[i] && (outstanding[i] < MAX_CNT);
         if (outstanding[i] != 2'd0) all_idle = 1'b0;
      end
   end

   // Scan from farthest to nearest so the lane closest after ptr is the one left standing.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int k = NUM_LANES; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_LANES;
         if (eligible[idx]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         bus.s_ready   <= 1'b0;
         bus.lane_ld   <= '0;
         bus.lane_data <= '0;
         hold_last     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         ptr           <= PTR_W'(NUM_LANES - 1);
      end else begin
         bus.lane_ld <= '0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= FETCH;
                  bus.s_ready <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
               end
            end
            FETCH: begin
               if (bus.s_valid && bus.s_ready) begin
                  bus.lane_data <= bus.s_data;
                  hold_last     <= bus.s_last;
                  bus.s_ready   <= 1'b0;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (grant_found) begin
                  bus.lane_ld <= NUM_LANES'(1) << grant_idx;
                  ptr         <= grant_idx;
                  if (hold_last) begin
                     state <= DRAIN;
                  end else begin
                     state       <= FETCH;
                     bus.s_ready <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               // The final load strobe has not yet reached its counter in its own cycle.
               if (all_idle && (bus.lane_ld == '0)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               bus.s_ready <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_LANES; i++) outstanding[i] <= 2'd0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            case ({bus.lane_ld[i], bus.lane_done[i]})
               2'b10:   if (outstanding[i] != 2'd3) outstanding[i] <= outstanding[i] + 2'd1;
               2'b01:   if (outstanding[i] != 2'd0) outstanding[i] <= outstanding[i] - 2'd1;
               default: outstanding[i] <= outstanding[i];
            endcase
         end
      end
   end

`ifdef SM_DISPATCH_STATS_EN
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         disp_count <= '0;
      end else if (start && (state == IDLE || state == DONE)) begin
         disp_count <= '0;
      end else if (bus.lane_ld != '0) begin
         disp_count <= sat_inc(disp_count);
      end
   end
`else
   assign disp_count = '0;
`endif

endmodule

// File: tb/tb_sm_dispatcher.sv
// Scoreboard bench for sm_dispatcher: stimulus queues expected grants, a negedge monitor checks them.
module tb_sm_dispatcher;
   localparam int NL = 4;
   localparam int RW = 316;
   localparam int CW = 16;
`ifdef SM_DISPATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      int            lane;
      logic [RW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic [CW-1:0] disp_count;
   int            checks = 0;
   int            errors = 0;
   exp_t          q[$];
   exp_t          mon_e;

   sm_dispatcher_if #(.NUM_LANES(NL), .REC_WIDTH(RW)) bus ();

   sm_dispatcher #(.NUM_LANES(NL), .REC_WIDTH(RW), .MAX_OUT(2), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .disp_count (disp_count)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] mk(input int n);
      logic [47:0] id;
      id = 48'h5EC0_0000_0000 + 48'(n);
      return {id, 12'(n * 3 + 1), {8{32'hC0FFEE00 ^ 32'(n)}}};
   endfunction

   // Scoreboard monitor: every load strobe must match the oldest expected grant.
   always @(negedge clk) begin
      if (bus.lane_ld != '0) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL lane_ld_unexpected: got lane_ld=%b, required none", bus.lane_ld);
         end else begin
            mon_e = q.pop_front();
            if (bus.lane_ld != (4'b0001 << mon_e.lane) || bus.lane_data != mon_e.data) begin
               errors++;
               $display("FAIL grant: got lane_ld=%b data=%h, required lane_ld=%b data=%h",
                        bus.lane_ld, bus.lane_data, 4'b0001 << mon_e.lane, mon_e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic pulse_done(input logic [NL-1:0] m);
      @(negedge clk) bus.lane_done = m;
      @(negedge clk) bus.lane_done = '0;
   endtask

   task automatic send(input int n, input logic last, input int lane);
      int cnt;
      exp_t e;
      e.lane = lane;
      e.data = mk(n);
      q.push_back(e);
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = mk(n);
      bus.s_last  = last;
      cnt = 0;
      while (!bus.s_ready && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: record %0d not accepted, required acceptance", n);
      end
      @(posedge clk);
      #1 bus.s_valid = 1'b0;
   endtask

   task automatic wait_q_empty(input string name);
      int cnt;
      cnt = 0;
      while (q.size() != 0 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      chk(name, 64'(q.size()), 64'd0);
   endtask

   task automatic wait_done(input string name);
      int cnt;
      cnt = 0;
      while (!done && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk(name, 64'(done), 64'd1);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      bus.s_last = 1'b0;
      bus.lane_full = '0;
      bus.lane_done = '0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
      chk("rst_lane_ld", 64'(bus.lane_ld), 64'd0);
      chk("rst_lane_data_zero", 64'(bus.lane_data == '0), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_disp_count", 64'(disp_count), 64'd0);
      rst = 1'b1;

      // Plain pass: four records fan out 0,1,2,3.
      pulse_start();
      chk("a_busy_fetch", 64'(busy), 64'd1);
      chk("a_s_ready_fetch", 64'(bus.s_ready), 64'd1);
      for (int i = 0; i < 4; i++) send(i, i == 3, i);
      wait_q_empty("a_grants_issued");
      chk("a_busy_drain", 64'(busy), 64'd1);
      for (int i = 0; i < 3; i++) pulse_done(4'b0001 << i);
      @(negedge clk);
      chk("a_not_done_yet", 64'(done), 64'd0);
      pulse_done(4'b1000);
      wait_done("a_done");
      chk("a_busy_idle", 64'(busy), 64'd0);
      chk("a_disp_count", 64'(disp_count), STATS ? 64'd4 : 64'd0);

      // Lane 1 full: grants skip it.
      bus.lane_full = 4'b0010;
      pulse_start();
      chk("b_disp_cleared", 64'(disp_count), 64'd0);
      send(10, 1'b0, 0);
      send(11, 1'b0, 2);
      send(12, 1'b1, 3);
      wait_q_empty("b_grants_issued");
      bus.lane_full = '0;
      pulse_done(4'b1101);
      wait_done("b_done");

      // Credit exhaustion: eight go out, ninth waits for lane 2 to free a slot.
      pulse_start();
      for (int i = 0; i < 8; i++) send(20 + i, 1'b0, i % 4);
      send(28, 1'b1, 2);
      repeat (6) @(negedge clk);
      chk("c_stall_pending", 64'(q.size()), 64'd1);
      chk("c_stall_s_ready", 64'(bus.s_ready), 64'd0);
      chk("c_stall_busy", 64'(busy), 64'd1);
      chk("c_held_data", 64'(bus.lane_data == mk(28)), 64'd1);
      pulse_done(4'b0100);
      wait_q_empty("c_ninth_to_lane2");
      pulse_done(4'b1111);
      pulse_done(4'b1111);
      wait_done("c_done");

      // Load and done on lane 0 in the same cycle; spurious done on idle lane 3.
      bus.lane_full = 4'b1110;
      pulse_start();
      send(30, 1'b0, 0);
      send(31, 1'b1, 0);
      begin
         int cnt;
         cnt = 0;
         @(negedge clk);
         while (!bus.lane_ld[0] && cnt < 20) begin
            @(negedge clk);
            cnt++;
         end
         bus.lane_done = 4'b0001;
         @(negedge clk) bus.lane_done = '0;
      end
      bus.lane_full = '0;
      repeat (5) @(negedge clk);
      chk("d_lane0_still_out", 64'(done), 64'd0);
      pulse_done(4'b1000);
      pulse_done(4'b0001);
      wait_done("d_done_no_underflow");

      // Reset while a record is stalled in ISSUE.
      bus.lane_full = 4'b1111;
      pulse_start();
      send(40, 1'b0, 0);
      void'(q.pop_back());
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("e_rst_lane_ld", 64'(bus.lane_ld), 64'd0);
      chk("e_rst_s_ready", 64'(bus.s_ready), 64'd0);
      chk("e_rst_busy", 64'(busy), 64'd0);
      chk("e_rst_done", 64'(done), 64'd0);
      chk("e_rst_lane_data_zero", 64'(bus.lane_data == '0), 64'd1);
      chk("e_rst_disp_count", 64'(disp_count), 64'd0);
      rst = 1'b1;
      bus.lane_full = '0;
      repeat (5) @(negedge clk);
      chk("e_idle_busy", 64'(busy), 64'd0);
      chk("e_idle_s_ready", 64'(bus.s_ready), 64'd0);

      // Fresh pointer after reset; five records exercise the counter.
      pulse_start();
      for (int i = 0; i < 5; i++) send(50 + i, i == 4, i % 4);
      wait_q_empty("f_grants_issued");
      @(negedge clk);
      chk("f_disp_count", 64'(disp_count), STATS ? 64'd5 : 64'd0);
      pulse_done(4'b1111);
      pulse_done(4'b0001);
      wait_done("f_done");
      pulse_start();
      chk("f_disp_cleared", 64'(disp_count), 64'd0);
      chk("f_busy_restart", 64'(busy), 64'd1);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
